u_rf_sb: RTL and testbench
==========================

U_RF_SB -- requirements
Module: u_rf_sb

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers.
REQ-002 Parameter CNTW, default 3, width of each per-register pending counter.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 rs1_a  in  5  read port 1 address from decode.
REQ-006 rs2_a  in  5  read port 2 address from decode.
REQ-007 rs1_re  in  1  port 1 operand is used by the decoded instruction.
REQ-008 rs2_re  in  1  port 2 operand is used by the decoded instruction.
REQ-009 rf_rs1_o  out  32  port 1 read data.
REQ-010 rf_rs2_o  out  32  port 2 read data.
REQ-011 rf_rd_e  in  1  write enable from the execute write buffer.
REQ-012 rf_rd_a  in  5  write address.
REQ-013 rf_rd_i  in  32  write data.
REQ-014 issue_e  in  1  decoded instruction that writes rd is accepted into execute this cycle.
REQ-015 issue_a  in  5  destination register of the issued instruction.
REQ-016 flush0  in  1  the instruction latched into execute on the previous edge is cancelled.
REQ-017 stall  out  1  decode shall hold; a used source operand has a write pending.
REQ-018 sb_err  out  1  sticky flag; counter overflow or underflow detected.

Function
REQ-019 Storage: NREG x 32-bit registers; x0 reads 0 at all times, and writes to x0 are discarded.
REQ-020 Reads are combinational on rs1_a/rs2_a; zero read latency.
REQ-021 Write-through bypass: when rf_rd_e=1, rf_rd_a matches a read address, and rf_rd_a is nonzero, that port returns rf_rd_i in the same cycle.
REQ-022 Writes commit on the clock edge when rf_rd_e=1.
REQ-023 Per-register pending counter pend[r], CNTW bits; pend[0] is forced to 0.
REQ-024 Each edge, pend[r] += inc[r] - dec[r] - kill[r], with the three terms defined below.
REQ-025 inc[r] = issue_e & !stall & issue_a==r & r!=0.
REQ-026 dec[r] = rf_rd_e & rf_rd_a==r & r!=0.
REQ-027 kill[r] = flush0 & last_v & last_a==r.
REQ-028 last_v/last_a register the accepted issue_e/issue_a of the previous cycle; last_v clears on flush0.
REQ-029 Simultaneous inc and dec on the same register leave pend unchanged; inc, dec and kill together decrement it by 1.
REQ-030 Overflow: an increment at pend=all-ones holds pend and sets sb_err.
REQ-031 Underflow: a decrement or kill at pend=0 holds pend at 0 and sets sb_err.
REQ-032 busy(r) = pend[r]!=0, except when dec[r]=1 and pend[r]=1, in which case the register is not busy (the bypass covers it).
REQ-033 stall = (rs1_re & busy(rs1_a)) | (rs2_re & busy(rs2_a)); stall is combinational, and x0 never stalls.
REQ-034 While stall=1, issue_e is ignored (no inc); decode re-presents the instruction next cycle.
REQ-035 Execute write latency is fixed at 4 edges after issue; a single write in flight blocks a dependent read for 3 cycles and is bypassed in the 4th.

Reset
REQ-036 On rstn low, all registers clear to 0, as do all pend counters, last_v, last_a and sb_err.
REQ-037 Outputs during reset: rf_rs1_o=0, rf_rs2_o=0, stall=0, sb_err=0.
REQ-038 Reset asserted mid-operation discards all pending writes; writes arriving after release are counted as underflow only if pend=0 and the address is nonzero.

Structure
REQ-039 Shared package rv_pkg holds XLEN=32, NREG=32 and the regaddr_t (5-bit) type; this block imports it.
REQ-040 One sub-module, u_sb_cnt: a single saturating up/down pending counter with an err output, instantiated NREG-1 times.
REQ-041 Register array and bypass logic reside in u_rf_sb itself; no memory macro is used.

Verification
REQ-042 Write x5=0x12345678 with no issue pending, then read rs1_a=5 the next cycle -> rf_rs1_o=0x12345678, stall=0.
REQ-043 Issue rd=7, then present rs2_a=7 with rs2_re=1 -> stall=1 for 3 cycles; on the 4th cycle rf_rd_e=1 (a=7, d=0xA5A5A5A5) -> stall=0 and rf_rs2_o=0xA5A5A5A5.
REQ-044 Issue rd=9, then assert flush0 the next cycle -> pend[9] returns to 0, a read of x9 does not stall, and sb_err=0.
REQ-045 Write x0=0xFFFFFFFF and issue rd=0, then read rs1_a=0 with rs1_re=1 -> rf_rs1_o=0, stall=0.
REQ-046 Issue rd=3 eight times with no write, then assert rf_rd_e to x4 while pend[4]=0 -> pend[3] saturates at 7 and sb_err=1 (sticky); a reset pulse clears all counters and sb_err.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv_pkg
// Brief    : Shared integer-core constants and register-address type.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef logic [4:0] regaddr_t;

endpackage
`default_nettype wire

// File: rtl/u_sb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : u_sb_cnt
// Brief    : Saturating up/down pending-write counter with over/underflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module u_sb_cnt
    import rv_pkg::*;
#(
    parameter int CNTW = 3   // must be >= 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_inc,
    input  logic            i_dec,
    input  logic            i_kill,
    output logic [CNTW-1:0] o_cnt,
    output logic            o_err
);

    logic [CNTW-1:0] r_cnt;
    logic [2:0]      w_delta;
    logic [CNTW+1:0] w_sum;
    logic            w_over;
    logic            w_under;

    // Net change lies in [-2, +1]; two guard bits expose both overflow and underflow.
    assign w_delta = {2'b00, i_inc} - {2'b00, i_dec} - {2'b00, i_kill};
    assign w_sum   = {2'b00, r_cnt} + {{(CNTW-1){w_delta[2]}}, w_delta};
    assign w_under = w_sum[CNTW+1];
    assign w_over  = w_sum[CNTW] & ~w_sum[CNTW+1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_under) begin
            r_cnt <= '0;
        end else if (!w_over) begin
            r_cnt <= w_sum[CNTW-1:0];
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = w_over | w_under;

endmodule
`default_nettype wire

// File: rtl/u_rf_sb.sv
`default_nettype none
// ============================================================================
// Module   : u_rf_sb
// Brief    : Two-read/one-write register file with write-through bypass and a
//            per-register pending-write scoreboard driving the decode stall.
// Revision : 1.0 - initial release
// ============================================================================
module u_rf_sb
    import rv_pkg::*;
#(
    parameter int NREG = 32,
    parameter int CNTW = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  rs1_a,
    input  logic [4:0]  rs2_a,
    input  logic        rs1_re,
    input  logic        rs2_re,
    output logic [31:0] rf_rs1_o,
    output logic [31:0] rf_rs2_o,
    input  logic        rf_rd_e,
    input  logic [4:0]  rf_rd_a,
    input  logic [31:0] rf_rd_i,
    input  logic        issue_e,
    input  logic [4:0]  issue_a,
    input  logic        flush0,
    output logic        stall,
    output logic        sb_err
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            r_last_v;
    regaddr_t        r_last_a;
    logic            r_sb_err;

    logic [31:0]     w_busy;
    logic [31:0]     w_err;
    logic            w_stall;
    logic            w_accept;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;

    assign w_accept = issue_e & ~w_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (rf_rd_e && (rf_rd_a != '0) && (int'(rf_rd_a) < NREG)) begin
            r_regs[rf_rd_a] <= rf_rd_i;
        end
    end

    always_comb begin
        w_rs1 = '0;
        if ((rs1_a != '0) && (int'(rs1_a) < NREG)) begin
            w_rs1 = (rf_rd_e && (rf_rd_a == rs1_a)) ? rf_rd_i : r_regs[rs1_a];
        end
    end

    always_comb begin
        w_rs2 = '0;
        if ((rs2_a != '0) && (int'(rs2_a) < NREG)) begin
            w_rs2 = (rf_rd_e && (rf_rd_a == rs2_a)) ? rf_rd_i : r_regs[rs2_a];
        end
    end

    // Bypass data must not leak out while the file is held in reset.
    assign rf_rs1_o = rstn ? w_rs1 : '0;
    assign rf_rs2_o = rstn ? w_rs2 : '0;

    generate
        for (genvar r = 0; r < 32; r++) begin : g_reg
            if ((r > 0) && (r < NREG)) begin : g_cnt
                logic [CNTW-1:0] w_cnt;
                logic            w_dec;
                logic            w_inc;
                logic            w_kill;

                assign w_inc  = w_accept & (issue_a == regaddr_t'(r));
                assign w_dec  = rf_rd_e & (rf_rd_a == regaddr_t'(r));
                assign w_kill = flush0 & r_last_v & (r_last_a == regaddr_t'(r));

                u_sb_cnt #(.CNTW(CNTW)) u_cnt (
                    .clk    (clk),
                    .rstn   (rstn),
                    .i_inc  (w_inc),
                    .i_dec  (w_dec),
                    .i_kill (w_kill),
                    .o_cnt  (w_cnt),
                    .o_err  (w_err[r])
                );

                // Last outstanding write landing this cycle is served by the bypass.
                assign w_busy[r] = (w_cnt != '0) & ~(w_dec & (w_cnt == CNTW'(1)));
            end else begin : g_none
                assign w_busy[r] = 1'b0;
                assign w_err[r]  = 1'b0;
            end
        end
    endgenerate

    assign w_stall = (rs1_re & w_busy[rs1_a]) | (rs2_re & w_busy[rs2_a]);
    assign stall   = w_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_v <= 1'b0;
            r_last_a <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_last_v <= w_accept & ~flush0;
            r_last_a <= issue_a;
            r_sb_err <= r_sb_err | (|w_err);
        end
    end

    assign sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_u_rf_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_u_rf_sb
// Brief    : Self-checking bench for u_rf_sb: vector table, corner sequences,
//            and randomized traffic against a behavioural scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u_rf_sb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  rs1_a, rs2_a, rf_rd_a, issue_a;
    logic        rs1_re, rs2_re, rf_rd_e, issue_e, flush0;
    logic [31:0] rf_rd_i;
    logic [31:0] rf_rs1_o, rf_rs2_o;
    logic        stall, sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    u_rf_sb dut (
        .clk      (clk),
        .rstn     (rstn),
        .rs1_a    (rs1_a),
        .rs2_a    (rs2_a),
        .rs1_re   (rs1_re),
        .rs2_re   (rs2_re),
        .rf_rs1_o (rf_rs1_o),
        .rf_rs2_o (rf_rs2_o),
        .rf_rd_e  (rf_rd_e),
        .rf_rd_a  (rf_rd_a),
        .rf_rd_i  (rf_rd_i),
        .issue_e  (issue_e),
        .issue_a  (issue_a),
        .flush0   (flush0),
        .stall    (stall),
        .sb_err   (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [4:0]  a1, a2;
        bit          re1, re2;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ie;
        logic [4:0]  ia;
        bit          fl;
        logic [31:0] e1, e2;
        bit          est, eerr;
    } vec_t;

    vec_t vt[$];

    // Behavioural model: pending counts as plain integers, clamped by the rules.
    int          m_pend [32];
    logic [31:0] m_regs [32];
    bit          m_lv;
    int          m_la;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs1_a = 0; rs2_a = 0; rs1_re = 0; rs2_re = 0;
        rf_rd_e = 0; rf_rd_a = 0; rf_rd_i = 0;
        issue_e = 0; issue_a = 0; flush0 = 0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0;
            m_regs[i] = 0;
        end
        m_lv = 0; m_la = 0; m_err = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_reset();
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (rf_rd_e && int'(rf_rd_a) == a) return rf_rd_i;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input int a);
        if (a == 0 || m_pend[a] == 0) return 1'b0;
        if (rf_rd_e && int'(rf_rd_a) == a && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return (rs1_re && m_busy(int'(rs1_a))) || (rs2_re && m_busy(int'(rs2_a)));
    endfunction

    task automatic m_step();
        bit acc;
        int d, n;
        acc = issue_e && !m_stall();
        for (int r = 1; r < 32; r++) begin
            d = 0;
            if (acc && int'(issue_a) == r) d += 1;
            if (rf_rd_e && int'(rf_rd_a) == r) d -= 1;
            if (flush0 && m_lv && m_la == r) d -= 1;
            n = m_pend[r] + d;
            if (n < 0) begin
                n = 0; m_err = 1;
            end else if (n > 7) begin
                n = m_pend[r]; m_err = 1;
            end
            m_pend[r] = n;
        end
        if (rf_rd_e && rf_rd_a != 0) m_regs[rf_rd_a] = rf_rd_i;
        m_lv = acc && !flush0;
        m_la = int'(issue_a);
    endtask

    initial begin
        vec_t v;
        idle();
        rstn = 1'b0;
        m_reset();

        // Reset state, with a live bypass request that must stay hidden.
        repeat (2) @(posedge clk);
        rs1_a = 5; rs1_re = 1; rf_rd_e = 1; rf_rd_a = 5; rf_rd_i = 32'hDEADBEEF;
        #2;
        chk("rst_rs1", rf_rs1_o, 32'h0);
        chk("rst_rs2", rf_rs2_o, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_err", {31'b0, sb_err}, 32'h0);
        idle();
        @(posedge clk); #1;
        rstn = 1'b1;

        //        rst a1 a2 re1 re2 we wa  wd            ie ia fl  e1            e2            st err
        // Write-then-read x5 (an unissued write counts as underflow)
        vt.push_back('{1, 0, 0, 0, 0, 1, 5, 32'h12345678, 0, 0, 0, 32'h0,        32'h0,        0, 0});
        vt.push_back('{0, 5, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h12345678, 32'h0,        0, 1});
        // x0 write and x0 issue are inert
        vt.push_back('{0, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        32'h0,        0, 1});
        vt.push_back('{0, 0, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h12345678, 0, 1});
        // Issue x7; dependent read stalls 3 cycles; issue of x8 while stalled is dropped
        vt.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 7, 0, 32'h0,        32'h0,        0, 0});
        vt.push_back('{0, 0, 7, 0, 1, 0, 0, 32'h0,        1, 8, 0, 32'h0,        32'h0,        1, 0});
        vt.push_back('{0, 0, 7, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0});
        vt.push_back('{0, 0, 7, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 0});
        vt.push_back('{0, 0, 7, 0, 1, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        32'hA5A5A5A5, 0, 0});
        vt.push_back('{0, 8, 7, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'hA5A5A5A5, 0, 0});
        // Issue x9 then flush it
        vt.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 9, 0, 32'h0,        32'h0,        0, 0});
        vt.push_back('{0, 9, 0, 1, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,        1, 0});
        vt.push_back('{0, 9, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0});
        vt.push_back('{0, 9, 0, 1, 0, 1, 9, 32'h00000001, 0, 0, 0, 32'h00000001, 32'h0,        0, 0});
        vt.push_back('{0, 9, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h00000001, 32'h0,        0, 1});

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            if (v.rst) begin
                idle();
                do_reset();
            end
            rs1_a = v.a1; rs2_a = v.a2; rs1_re = v.re1; rs2_re = v.re2;
            rf_rd_e = v.we; rf_rd_a = v.wa; rf_rd_i = v.wd;
            issue_e = v.ie; issue_a = v.ia; flush0 = v.fl;
            @(negedge clk);
            chk($sformatf("vec%0d_rs1", i), rf_rs1_o, v.e1);
            chk($sformatf("vec%0d_rs2", i), rf_rs2_o, v.e2);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, v.est});
            chk($sformatf("vec%0d_err", i), {31'b0, sb_err}, {31'b0, v.eerr});
            @(posedge clk); #1;
        end

        // Counter saturation: eight issues of x3 overflow a 3-bit count at 7
        idle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue_e = 1; issue_a = 3;
            @(negedge clk);
            chk($sformatf("sat_issue%0d_err", i), {31'b0, sb_err}, 32'h0);
            @(posedge clk); #1;
        end
        idle();
        rf_rd_e = 1; rf_rd_a = 4; rf_rd_i = 32'h44;
        @(negedge clk);
        chk("sat_err_set", {31'b0, sb_err}, 32'h1);
        @(posedge clk); #1;
        for (int k = 1; k <= 7; k++) begin
            rs1_a = 3; rs1_re = 1;
            rf_rd_e = 1; rf_rd_a = 3; rf_rd_i = k;
            @(negedge clk);
            chk($sformatf("drain%0d_stall", k), {31'b0, stall}, (k < 7) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        rf_rd_e = 0;
        @(negedge clk);
        chk("drained_stall", {31'b0, stall}, 32'h0);
        chk("sticky_err", {31'b0, sb_err}, 32'h1);
        chk("drained_rs1", rf_rs1_o, 32'h7);
        rstn = 1'b0;
        #2;
        chk("rst_pulse_err", {31'b0, sb_err}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        m_reset();
        @(negedge clk);
        chk("post_rst_err", {31'b0, sb_err}, 32'h0);
        chk("post_rst_rs1", rf_rs1_o, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic over x0..x7 against the model, with periodic resets
        idle();
        do_reset();
        for (int c = 0; c < 450; c++) begin
            int wa;
            if (c % 150 == 149) begin
                idle();
                do_reset();
            end
            rs1_a = 5'($urandom_range(0, 7));
            rs2_a = 5'($urandom_range(0, 7));
            rs1_re = 1'($urandom_range(0, 1));
            rs2_re = 1'($urandom_range(0, 1));
            wa = $urandom_range(0, 7);
            rf_rd_a = 5'(wa);
            rf_rd_i = $urandom;
            rf_rd_e = (m_pend[wa] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            issue_e = 1'($urandom_range(0, 1));
            issue_a = 5'($urandom_range(0, 7));
            flush0 = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            chk("rnd_rs1", rf_rs1_o, m_read(int'(rs1_a)));
            chk("rnd_rs2", rf_rs2_o, m_read(int'(rs2_a)));
            chk("rnd_stall", {31'b0, stall}, {31'b0, m_stall()});
            chk("rnd_err", {31'b0, sb_err}, {31'b0, m_err});
            @(posedge clk); #1;
            m_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
